mode_result_router: RTL

// - Write-back counterpart of the mode operand selector. Accepts one or two results per

---
 rtl/mode_sel_pkg.sv | 44 ++++
 rtl/mode_result_router.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mode_sel_pkg.sv
// Shared mode/slot encodings for the operand selector and the result router.
// Holds the router FSM state type and the mode decode helpers.
package mode_sel_pkg;

    typedef enum logic [2:0] {
        MODE_0 = 3'd0,
        MODE_1 = 3'd1,
        MODE_2 = 3'd2,
        MODE_3 = 3'd3,
        MODE_4 = 3'd4,
        MODE_5 = 3'd5,
        MODE_6 = 3'd6,
        MODE_7 = 3'd7
    } mode_e;

    localparam logic [1:0] SLOT1 = 2'd0;
    localparam logic [1:0] SLOT2 = 2'd1;
    localparam logic [1:0] SLOT3 = 2'd2;
    localparam logic [1:0] SLOT4 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR1  = 2'd1,
        WR2  = 2'd2
    } router_state_e;

    function automatic logic mode_is_dual(input logic [2:0] mode);
        return (mode == MODE_2) || (mode == MODE_3);
    endfunction

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return (mode != MODE_6) && (mode != MODE_7);
    endfunction

    // Slot map is the inverse of operand selection: mode 2 writes slot2 then slot1.
    function automatic logic [1:0] first_slot(input logic [2:0] mode);
        return (mode == MODE_2) ? SLOT2 : SLOT3;
    endfunction

    function automatic logic [1:0] second_slot(input logic [2:0] mode);
        return (mode == MODE_2) ? SLOT1 : SLOT4;
    endfunction

endpackage

// File: rtl/mode_result_router.sv
// Writes one or two execution results back to operand slots through a single write port.
// Optional macro MODE_ERR_COUNT_EN adds a saturating illegal-mode counter on err_count.
module mode_result_router
    import mode_sel_pkg::*;
#(
    parameter int n         = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           select,
    input  logic [n-1:0]         res1,
    input  logic [n-1:0]         res2,
    input  logic                 res_valid,
    output logic                 res_ready,
    output logic                 wr_en,
    output logic [1:0]           wr_addr,
    output logic [n-1:0]         wr_data,
    output logic                 busy,
    output logic                 mode_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    router_state_e  state_q, state_d;
    logic [2:0]     sel_q, sel_d;
    logic [n-1:0]   res2_q, res2_d;
    logic           wr_en_q, wr_en_d;
    logic [1:0]     wr_addr_q, wr_addr_d;
    logic [n-1:0]   wr_data_q, wr_data_d;
    logic           busy_q, busy_d;
    logic           mode_err_q, mode_err_d;
    logic           accept;

    // Ready whenever the current cycle is the last write of an op (or no op at all).
    assign res_ready = rst_n && ((state_q == IDLE) || (state_q == WR2) ||
                                 ((state_q == WR1) && !mode_is_dual(sel_q)));
    assign accept    = res_valid && res_ready;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        res2_d     = res2_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mode_err_d = 1'b0;
        if ((state_q == WR1) && mode_is_dual(sel_q)) begin
            state_d   = WR2;
            wr_en_d   = 1'b1;
            wr_addr_d = second_slot(sel_q);
            wr_data_d = res2_q;
        end else if (accept) begin
            sel_d  = select;
            res2_d = res2;
            if (mode_is_legal(select)) begin
                state_d   = WR1;
                wr_en_d   = 1'b1;
                wr_addr_d = first_slot(select);
                wr_data_d = res1;
            end else begin
                state_d    = IDLE;
                mode_err_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            res2_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            mode_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            res2_q     <= res2_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            mode_err_q <= mode_err_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign mode_err = mode_err_q;

`ifdef MODE_ERR_COUNT_EN
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (mode_err_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = '0;
`endif

endmodule
